// File: rtl/stream_switch_axil_reg_slave.sv
// AXI-Lite register file slave for one stream-switch address window.
// Holds NUM_REGS 32-bit words and supports read-only status slots. It exposes register values and write strobes.
module stream_switch_axil_reg_slave #(
  parameter int unsigned         NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [31:0]         RESET_VAL = 32'h0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axil_awvalid,
  input  logic [31:0]              s_axil_awaddr,
  output logic                     s_axil_awready,
  input  logic                     s_axil_wvalid,
  input  logic [31:0]              s_axil_wdata,
  output logic                     s_axil_wready,
  output logic                     s_axil_bvalid,
  output logic [1:0]               s_axil_bresp,
  input  logic                     s_axil_bready,
  input  logic                     s_axil_arvalid,
  input  logic [31:0]              s_axil_araddr,
  output logic                     s_axil_arready,
  output logic                     s_axil_rvalid,
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  input  logic                     s_axil_rready,
  output logic [32*NUM_REGS-1:0]   reg_out,
  input  logic [32*NUM_REGS-1:0]   reg_in,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [31:0] ADDR_LIMIT  = 32'(4 * NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][31:0] reg_in_a, reg_out_a;

  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic             aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign reg_in_a = reg_in;

  // Read-only slots mirror their status input directly
  always_comb begin
    reg_out_a = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      reg_out_a[i] = RO_MASK[i] ? reg_in_a[i] : regs_q[i];
    end
  end

  assign reg_out        = reg_out_a;
  assign wr_pulse       = wr_pulse_q;
  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  always_comb begin
    regs_d     = regs_q;
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wr_pulse_d = '0;

    aw_hs  = s_axil_awvalid & awready_q;
    w_hs   = s_axil_wvalid & wready_q;
    ar_hs  = s_axil_arvalid & arready_q;
    rd_idx = s_axil_araddr[2 +: IDX_W];

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr;
      awready_d = 1'b0;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wready_d = 1'b0;
    end
    wr_idx = awaddr_d[2 +: IDX_W];

    // Commit as soon as both halves are present; readies stay low until B completes
    if (aw_held_d && w_held_d) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if ((awaddr_d < ADDR_LIMIT) && !RO_MASK[wr_idx]) begin
        regs_d[wr_idx]     = wdata_d;
        wr_pulse_d[wr_idx] = 1'b1;
        bresp_d            = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    if (bvalid_q && s_axil_bready) begin
      bvalid_d  = 1'b0;
      awready_d = 1'b1;
      wready_d  = 1'b1;
    end

    // Reads use regs_q, so a same-edge write commit is not yet visible
    if (ar_hs) begin
      rvalid_d  = 1'b1;
      arready_d = 1'b0;
      if (s_axil_araddr < ADDR_LIMIT) begin
        rdata_d = RO_MASK[rd_idx] ? reg_in_a[rd_idx] : regs_q[rd_idx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = 32'h0;
        rresp_d = RESP_SLVERR;
      end
    end

    if (rvalid_q && s_axil_rready) begin
      rvalid_d  = 1'b0;
      arready_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      regs_q     <= {NUM_REGS{RESET_VAL}};
      aw_held_q  <= 1'b0;
      awaddr_q   <= 32'h0;
      w_held_q   <= 1'b0;
      wdata_q    <= 32'h0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

endmodule

// File: tb/tb_stream_switch_axil_reg_slave.sv
// Scoreboard bench for stream_switch_axil_reg_slave: expected B/R responses are queued
// when a transaction is driven and compared when the DUT presents them.
module tb_stream_switch_axil_reg_slave;

  localparam int unsigned   N  = 16;
  localparam logic [N-1:0]  RO = 16'h0001;
  localparam logic [31:0]   RV = 32'hDEAD_0000;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            s_axil_awvalid, s_axil_awready;
  logic [31:0]     s_axil_awaddr;
  logic            s_axil_wvalid, s_axil_wready;
  logic [31:0]     s_axil_wdata;
  logic            s_axil_bvalid, s_axil_bready;
  logic [1:0]      s_axil_bresp;
  logic            s_axil_arvalid, s_axil_arready;
  logic [31:0]     s_axil_araddr;
  logic            s_axil_rvalid, s_axil_rready;
  logic [31:0]     s_axil_rdata;
  logic [1:0]      s_axil_rresp;
  logic [32*N-1:0] reg_out, reg_in;
  logic [N-1:0]    wr_pulse;

  always #5 aclk = ~aclk;

  stream_switch_axil_reg_slave #(.NUM_REGS(N), .RO_MASK(RO), .RESET_VAL(RV)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(s_axil_awready),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wready(s_axil_wready),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr), .s_axil_arready(s_axil_arready),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rready(s_axil_rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  typedef struct packed { logic [1:0] resp; logic [N-1:0] pulse; } b_exp_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [N];
  b_exp_t      bq [$];
  r_exp_t      rq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic r_exp_t exp_read(input logic [31:0] a);
    r_exp_t e;
    int i = int'(a[5:2]);
    if (a >= 32'd64) begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end else begin
      e.data = RO[i] ? reg_in[i*32 +: 32] : mdl[i];
      e.resp = 2'b00;
    end
    return e;
  endfunction

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    b_exp_t e;
    int i = int'(a[5:2]);
    e.pulse = '0;
    if (a < 32'd64 && !RO[i]) begin
      e.resp     = 2'b00;
      e.pulse[i] = 1'b1;
      mdl[i]     = d;
    end else begin
      e.resp = 2'b10;
    end
    bq.push_back(e);
  endtask

  task automatic pop_b(input string tag, output b_exp_t e);
    e = '0;
    if (bq.size() == 0) begin
      check({tag, "_bq_empty"}, 32'd1, 32'd0);
      return;
    end
    e = bq.pop_front();
    check({tag, "_bresp"}, 32'(s_axil_bresp), 32'(e.resp));
    check({tag, "_wr_pulse"}, 32'(wr_pulse), 32'(e.pulse));
  endtask

  task automatic pop_r(input string tag, output r_exp_t e);
    e = '0;
    if (rq.size() == 0) begin
      check({tag, "_rq_empty"}, 32'd1, 32'd0);
      return;
    end
    e = rq.pop_front();
    check({tag, "_rdata"}, s_axil_rdata, e.data);
    check({tag, "_rresp"}, 32'(s_axil_rresp), 32'(e.resp));
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < int'(N); i++)
      check($sformatf("%s_reg%0d", tag, i), reg_out[i*32 +: 32], RO[i] ? reg_in[i*32 +: 32] : mdl[i]);
  endtask

  // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW
  task automatic axil_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input int lead, input int b_delay);
    bit     aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
    int     cyc = 0;
    int     gap = (lead < 0) ? -lead : lead;
    b_exp_t e;
    push_write(a, d);
    if (lead >= 0) begin s_axil_awvalid = 1'b1; s_axil_awaddr = a; end
    if (lead <= 0) begin s_axil_wvalid = 1'b1; s_axil_wdata = d; end
    while ((aw_pend || w_pend) && cyc < 50) begin
      @(negedge aclk);
      if (!aw_pend && w_pend) check({tag, "_awready_held_low"}, 32'(s_axil_awready), 32'd0);
      if (aw_pend && !w_pend) check({tag, "_wready_held_low"}, 32'(s_axil_wready), 32'd0);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      @(posedge aclk); #1;
      cyc++;
      if (aw_hs) begin s_axil_awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin s_axil_wvalid  = 1'b0; w_pend  = 1'b0; end
      if (aw_pend && !s_axil_awvalid && cyc >= gap) begin s_axil_awvalid = 1'b1; s_axil_awaddr = a; end
      if (w_pend && !s_axil_wvalid && cyc >= gap) begin s_axil_wvalid = 1'b1; s_axil_wdata = d; end
    end
    if (aw_pend || w_pend) begin
      check({tag, "_handshake_timeout"}, 32'd1, 32'd0);
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      return;
    end
    @(negedge aclk);
    check({tag, "_bvalid"}, 32'(s_axil_bvalid), 32'd1);
    pop_b(tag, e);
    check({tag, "_reg_out"}, reg_out[int'(a[5:2])*32 +: 32],
          RO[int'(a[5:2])] ? reg_in[int'(a[5:2])*32 +: 32] : mdl[int'(a[5:2])]);
    for (int k = 0; k < b_delay; k++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check({tag, "_bvalid_hold"}, 32'(s_axil_bvalid), 32'd1);
      check({tag, "_bresp_hold"}, 32'(s_axil_bresp), 32'(e.resp));
      check({tag, "_no_second_pulse"}, 32'(wr_pulse), 32'd0);
      check({tag, "_awready_low_in_b"}, 32'(s_axil_awready), 32'd0);
    end
    @(posedge aclk); #1; s_axil_bready = 1'b1;
    @(posedge aclk); #1; s_axil_bready = 1'b0;
    @(negedge aclk);
    check({tag, "_bvalid_clear"}, 32'(s_axil_bvalid), 32'd0);
    check({tag, "_awready_back"}, 32'(s_axil_awready), 32'd1);
    check({tag, "_wready_back"}, 32'(s_axil_wready), 32'd1);
    @(posedge aclk); #1;
  endtask

  task automatic axil_read(input string tag, input logic [31:0] a, input int r_delay);
    r_exp_t e;
    int     n = 0;
    rq.push_back(exp_read(a));
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = a;
    @(negedge aclk);
    while (!s_axil_arready && n < 50) begin @(negedge aclk); n++; end
    if (!s_axil_arready) begin
      check({tag, "_arready_timeout"}, 32'd1, 32'd0);
      s_axil_arvalid = 1'b0;
      return;
    end
    @(posedge aclk); #1; s_axil_arvalid = 1'b0;
    @(negedge aclk);
    check({tag, "_rvalid"}, 32'(s_axil_rvalid), 32'd1);
    check({tag, "_arready_low"}, 32'(s_axil_arready), 32'd0);
    pop_r(tag, e);
    for (int k = 0; k < r_delay; k++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check({tag, "_rvalid_hold"}, 32'(s_axil_rvalid), 32'd1);
      check({tag, "_rdata_hold"}, s_axil_rdata, e.data);
    end
    @(posedge aclk); #1; s_axil_rready = 1'b1;
    @(posedge aclk); #1; s_axil_rready = 1'b0;
    @(negedge aclk);
    check({tag, "_rvalid_clear"}, 32'(s_axil_rvalid), 32'd0);
    check({tag, "_arready_back"}, 32'(s_axil_arready), 32'd1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  initial begin
    b_exp_t      be;
    r_exp_t      re;
    logic [31:0] a, d;
    aresetn        = 1'b0;
    s_axil_awvalid = 1'b0; s_axil_awaddr = '0;
    s_axil_wvalid  = 1'b0; s_axil_wdata  = '0;
    s_axil_bready  = 1'b0;
    s_axil_arvalid = 1'b0; s_axil_araddr = '0;
    s_axil_rready  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      reg_in[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
      mdl[i] = RV;
    end
    reg_in[31:0] = 32'hCAFE_F00D;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("rst_awready", 32'(s_axil_awready), 32'd1);
    check("rst_wready", 32'(s_axil_wready), 32'd1);
    check("rst_arready", 32'(s_axil_arready), 32'd1);
    check("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    check("rst_rdata", s_axil_rdata, 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check_regs("rst");
    @(posedge aclk); #1;

    axil_write("w8", 32'h8, 32'hA5A5_0001, 0, 0);
    axil_read("r8", 32'h8, 0);
    axil_write("w4_aw_first", 32'h4, 32'h0000_1234, 3, 4);
    axil_write("w10_w_first", 32'h10, 32'h0BAD_CAFE, -2, 1);
    axil_write("w0_ro", 32'h0, 32'hFFFF_FFFF, 0, 0);
    axil_read("r0_ro", 32'h0, 2);
    axil_read("r40_oor", 32'h40, 0);
    axil_write("w1000_oor", 32'h1000, 32'h5555_AAAA, 0, 0);
    check_regs("after_oor");
    axil_read("r7_unaligned", 32'h7, 0);

    // AR and write commit to the same register on one edge
    axil_write("w3", 32'hC, 32'h11, 0, 0);
    rq.push_back(exp_read(32'hC));
    push_write(32'hC, 32'h22);
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'hC; s_axil_wvalid = 1'b1; s_axil_wdata = 32'h22;
    s_axil_arvalid = 1'b1; s_axil_araddr = 32'hC;
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    @(negedge aclk);
    check("coll_bvalid", 32'(s_axil_bvalid), 32'd1);
    check("coll_rvalid", 32'(s_axil_rvalid), 32'd1);
    pop_b("coll", be);
    pop_r("coll", re);
    check("coll_reg3", reg_out[3*32 +: 32], 32'h22);
    @(posedge aclk); #1; s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    @(posedge aclk); #1; s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    axil_read("r3_after", 32'hC, 0);

    for (int it = 0; it < 10; it++) begin
      a = 32'($urandom_range(0, 19)) << 2;
      d = $urandom;
      axil_write($sformatf("rnd_w%0d", it), a, d, $urandom_range(0, 4) - 2, $urandom_range(0, 2));
      axil_read($sformatf("rnd_r%0d", it), a | 32'($urandom_range(0, 3)), $urandom_range(0, 2));
    end
    check_regs("rnd");

    // Reset while both a B and an R response are pending
    axil_write("w5", 32'h14, 32'h55, 0, 0);
    rq.push_back(exp_read(32'h14));
    push_write(32'h18, 32'h66);
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h18; s_axil_wvalid = 1'b1; s_axil_wdata = 32'h66;
    s_axil_arvalid = 1'b1; s_axil_araddr = 32'h14;
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    @(negedge aclk);
    pop_b("pend", be);
    pop_r("pend", re);
    @(posedge aclk); #1; aresetn = 1'b0;
    @(posedge aclk); #1; aresetn = 1'b1;
    for (int i = 0; i < int'(N); i++) mdl[i] = RV;
    @(negedge aclk);
    check("mid_rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    check("mid_rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    check("mid_rst_awready", 32'(s_axil_awready), 32'd1);
    check("mid_rst_wready", 32'(s_axil_wready), 32'd1);
    check("mid_rst_arready", 32'(s_axil_arready), 32'd1);
    check("mid_rst_rdata", s_axil_rdata, 32'd0);
    check_regs("mid_rst");
    @(posedge aclk); #1;

    // A latched AW must not survive reset
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h20;
    @(posedge aclk); #1; s_axil_awvalid = 1'b0; aresetn = 1'b0;
    @(posedge aclk); #1; aresetn = 1'b1; s_axil_wvalid = 1'b1; s_axil_wdata = 32'h77;
    @(negedge aclk);
    check("aw_drop_wready", 32'(s_axil_wready), 32'd1);
    @(posedge aclk); #1; s_axil_wvalid = 1'b0;
    @(negedge aclk);
    check("aw_drop_no_bvalid", 32'(s_axil_bvalid), 32'd0);
    check("aw_drop_reg8", reg_out[8*32 +: 32], RV);
    push_write(32'h20, 32'h77);
    s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h20;
    @(posedge aclk); #1; s_axil_awvalid = 1'b0;
    @(negedge aclk);
    check("late_aw_bvalid", 32'(s_axil_bvalid), 32'd1);
    pop_b("late_aw", be);
    check("late_aw_reg8", reg_out[8*32 +: 32], 32'h77);
    @(posedge aclk); #1; s_axil_bready = 1'b1;
    @(posedge aclk); #1; s_axil_bready = 1'b0;
    repeat (2) @(posedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
